onewire_bus_master: RTL
=======================

Name: onewire_bus_master

Overview:
Synthesizable 1-Wire bus initiator. Generates reset/presence sequences and read/write time slots on an open-drain DQ line. Takes byte-level commands from a host over a valid/ready handshake and returns read bytes and presence status. Pairs with the team's behavioural 1-Wire slave model. Timing is counted in `clk` cycles, with defaults set for a 100 MHz clock.

Parameters:
T_RSTL, 48000, reset low time (cycles)
T_MSP, 1000, presence sample point after DQ release (cycles)
T_RSTH, 48000, total high time after reset low, incl. T_MSP (cycles)
T_SLOT, 7000, time slot length measured from the falling edge (cycles)
T_LOW1, 600, low time for write-1 and read-initiate (cycles)
T_LOW0, 6000, low time for write-0 (cycles)
T_RDS, 1500, read sample point after slot falling edge (cycles)
T_REC, 200, recovery high time between slots (cycles)
CNT_W, 16, timer width; must hold the largest parameter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  host command strobe
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  00=RESET, 01=WRITE_BYTE, 10=READ_BYTE, 11=reserved
cmd_data  in  8  byte to write, LSB first
resp_valid  out  1  one-cycle pulse when a command completes
resp_data  out  8  byte read; 0 for non-read ops
resp_presence  out  1  presence result of the last RESET
busy  out  1  high whenever not IDLE
dq_oe  out  1  1 = pull DQ low; the top level ties DQ to 1'bz when 0
dq_in  in  1  raw DQ level, asynchronous

Behaviour:
- Reset (reset=0) forces:
  - dq_oe=0, resp_valid=0, resp_data=0, resp_presence=0, busy=0, cmd_ready=1.
  - State=IDLE; timer, bit counter and shift register cleared.
- dq_in passes through a 2-FF synchronizer. All sampling uses the synced value, so sample points lag the true line by 2 cycles.
- Handshake:
  - A command is accepted on a cycle where cmd_valid&&cmd_ready.
  - cmd_op/cmd_data are latched on that cycle.
  - cmd_ready drops the next cycle and stays low until resp_valid has pulsed.
  - A reserved op completes immediately: resp_valid pulses the next cycle, with no bus activity.
- FSM states:
  - IDLE: wait for an accepted command. RESET->RST_LOW. WRITE/READ->SLOT_LOW with bit_cnt=0.
  - RST_LOW: dq_oe=1 for T_RSTL cycles, then release and go to RST_HIGH.
  - RST_HIGH: at timer==T_MSP, presence_q=~dq_sync. After T_RSTH cycles, resp_presence<=presence_q, then DONE.
  - SLOT_LOW: dq_oe=1.
    - Low time is T_LOW0 if writing bit 0, else T_LOW1 (write-1 and all read slots).
    - Then release and go to SLOT_HIGH; the timer continues from the falling edge.
  - SLOT_HIGH:
    - READ: at timer==T_RDS, shift_reg[bit_cnt]<=dq_sync.
    - At timer==T_SLOT go to SLOT_REC.
  - SLOT_REC: DQ released for T_REC cycles. Then bit_cnt++; if bit_cnt was 7 go to DONE, else SLOT_LOW.
  - DONE: resp_valid=1 for exactly one cycle, resp_data=shift_reg (READ) or 0. Next state IDLE.
- Latency, write-1 and read bytes: a byte is exactly 8*(T_SLOT+T_REC)+1 cycles from acceptance to resp_valid.
- Latency, write-0: the slot is stretched only if T_LOW0>T_SLOT.
- Latency, RESET: T_RSTL+T_RSTH+1 cycles.
- Timer is CNT_W bits and saturates at its maximum (never wraps). It is cleared at every state entry except SLOT_HIGH.
- resp_data and resp_presence hold their values until the next completion of the same kind.
- Async reset mid-slot releases DQ immediately and abandons the byte; no resp_valid is emitted.
- cmd_valid asserted while busy is ignored; it is not queued.
- If DQ is already low when a slot starts, behaviour is unchanged: timing is master-driven, with no wait for high.

Optional Feature:
ONEWIRE_CRC8_EN
- Defined:
  - Adds output crc8 [7:0], a Dallas/Maxim CRC (poly x^8+x^5+x^4+1, reflected, init 0).
  - Updated per bit at each READ sample point.
  - Cleared to 0 by reset and on acceptance of a RESET command.
  - crc8==0 after reading a payload plus its CRC byte means the data is valid.
- Undefined: no crc8 port and no CRC logic. All other behaviour is identical.

Test Plan:
- RESET op with the slave model attached -> dq_oe high for 48000 cycles; resp_valid after 96001 cycles; resp_presence=1.
- RESET op with no slave (DQ pulled up) -> resp_presence=0; resp_data=0.
- WRITE_BYTE 0x44 -> per-slot low widths, LSB first: 6000,6000,600,6000,6000,6000,600,6000 cycles; resp_valid once; the slave model decodes 0x44.
- READ_BYTE with the slave driving 0xCD (after 0x44, 0xBE) -> resp_data=0xCD; the next READ returns 0xAB.
- Assert reset at cycle 3000 of a WRITE_BYTE slot -> dq_oe=0 the same cycle; no resp_valid; a new RESET command is accepted afterwards; cmd_valid held during busy is not accepted.
- With ONEWIRE_CRC8_EN: read 0x02,0x1C,0xB8,0x01,0x00,0x00,0x00 then 0xA2 -> crc8=0x00; with 0xA3 as the last byte, crc8!=0.

Source files
------------

// File: rtl/onewire_bus_master.sv
// onewire_bus_master: byte-level 1-Wire bus initiator.
// It generates reset/presence sequences and read/write time slots on an
// open-drain DQ line. All timing is counted in clk cycles.
// Optional build macro ONEWIRE_CRC8_EN adds a running Dallas/Maxim CRC-8
// output (crc8) over the bits sampled in read slots.
module onewire_bus_master #(
    parameter int T_RSTL = 48000,
    parameter int T_MSP  = 1000,
    parameter int T_RSTH = 48000,
    parameter int T_SLOT = 7000,
    parameter int T_LOW1 = 600,
    parameter int T_LOW0 = 6000,
    parameter int T_RDS  = 1500,
    parameter int T_REC  = 200,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_presence,
    output logic       busy,
    output logic       dq_oe,
    input  logic       dq_in
`ifdef ONEWIRE_CRC8_EN
    ,
    output logic [7:0] crc8
`endif
);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // End-of-phase compare values; phases last N cycles so they end at N-1.
    localparam logic [CNT_W-1:0] L_RSTL_M1 = CNT_W'(T_RSTL - 1);
    localparam logic [CNT_W-1:0] L_RSTH_M1 = CNT_W'(T_RSTH - 1);
    localparam logic [CNT_W-1:0] L_SLOT_M1 = CNT_W'(T_SLOT - 1);
    localparam logic [CNT_W-1:0] L_LOW1_M1 = CNT_W'(T_LOW1 - 1);
    localparam logic [CNT_W-1:0] L_LOW0_M1 = CNT_W'(T_LOW0 - 1);
    localparam logic [CNT_W-1:0] L_REC_M1  = CNT_W'(T_REC - 1);
    localparam logic [CNT_W-1:0] L_MSP     = CNT_W'(T_MSP);
    localparam logic [CNT_W-1:0] L_RDS     = CNT_W'(T_RDS);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_LOW, S_RST_HIGH, S_SLOT_LOW, S_SLOT_HIGH, S_SLOT_REC, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [1:0]       r_op;
    logic [7:0]       r_wdata;
    logic             r_presence_q;
    logic [7:0]       r_resp_data;
    logic             r_resp_presence;
    logic [1:0]       r_sync;

    logic             w_accept;
    logic             w_dq_sync;
    logic             w_rd_sample;
    logic             w_presence;
    logic [CNT_W-1:0] w_low_m1;

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_dq_sync   = r_sync[1];
    assign w_rd_sample = (r_state == S_SLOT_HIGH) && (r_op == OP_READ) && (r_timer == L_RDS);
    // Presence captured at the sample point; bypass covers a sample on the last high cycle.
    assign w_presence  = (r_state == S_RST_HIGH && r_timer == L_MSP) ? ~w_dq_sync : r_presence_q;
    // Only a write-0 bit uses the long low time; write-1 and read slots use the short one.
    assign w_low_m1    = (r_op == OP_WRITE && !r_wdata[r_bit_cnt]) ? L_LOW0_M1 : L_LOW1_M1;

    assign resp_data     = r_resp_data;
    assign resp_presence = r_resp_presence;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; >= compares keep phases bounded even when the timer saturates
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_RESET:          w_state_next = S_RST_LOW;
                        OP_WRITE, OP_READ: w_state_next = S_SLOT_LOW;
                        default:           w_state_next = S_DONE;
                    endcase
                end
            end
            S_RST_LOW:   if (r_timer >= L_RSTL_M1) w_state_next = S_RST_HIGH;
            S_RST_HIGH:  if (r_timer >= L_RSTH_M1) w_state_next = S_DONE;
            S_SLOT_LOW:  if (r_timer >= w_low_m1)  w_state_next = S_SLOT_HIGH;
            S_SLOT_HIGH: if (r_timer >= L_SLOT_M1) w_state_next = S_SLOT_REC;
            S_SLOT_REC: begin
                if (r_timer >= L_REC_M1)
                    w_state_next = (r_bit_cnt == 3'd7) ? S_DONE : S_SLOT_LOW;
            end
            S_DONE:      w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        dq_oe      = 1'b0;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_RST_LOW, S_SLOT_LOW: dq_oe = 1'b1;
            S_DONE:                resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: synchronizer, phase timer, command latch, bit shifter, responses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync          <= 2'b11;
            r_timer         <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_op            <= '0;
            r_wdata         <= '0;
            r_presence_q    <= 1'b0;
            r_resp_data     <= '0;
            r_resp_presence <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], dq_in};

            // The timer keeps running into SLOT_HIGH so slot time is measured from the falling edge
            if (w_state_next != r_state && w_state_next != S_SLOT_HIGH)
                r_timer <= '0;
            else if (r_timer != '1)
                r_timer <= r_timer + 1'b1;

            if (w_accept) begin
                r_op      <= cmd_op;
                r_wdata   <= cmd_data;
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end

            r_presence_q <= w_presence;

            if (w_rd_sample)
                r_shift[r_bit_cnt] <= w_dq_sync;

            if (r_state == S_SLOT_REC && w_state_next != S_SLOT_REC)
                r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_state_next == S_DONE && r_state != S_DONE) begin
                r_resp_data <= (r_state != S_IDLE && r_op == OP_READ) ? r_shift : 8'h00;
                if (r_state == S_RST_HIGH)
                    r_resp_presence <= w_presence;
            end
        end
    end

`ifdef ONEWIRE_CRC8_EN
    logic [7:0] r_crc;
    logic       w_crc_fb;

    assign w_crc_fb = r_crc[0] ^ w_dq_sync;
    assign crc8     = r_crc;

    // Reflected CRC-8 (0x31 reversed = 0x8C), one bit per read sample point
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_crc <= 8'h00;
        else if (w_accept && cmd_op == OP_RESET)
            r_crc <= 8'h00;
        else if (w_rd_sample)
            r_crc <= {1'b0, r_crc[7:1]} ^ (w_crc_fb ? 8'h8C : 8'h00);
    end
`endif

endmodule
